sm_sat_accum: RTL and testbench

//  Parametrised sign-magnitude saturating accumulator with a valid/ready stream on both sides.

---
 rtl/sm_sat_accum_if.sv | 29 ++
 rtl/sm_sat_accum.sv | 106 ++++++++++
 tb/tb_sm_sat_accum.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_sat_accum_if.sv
// Stream bundle for the sign-magnitude accumulator: operand beats in, saturated frame sums out.
// The master drives operands and consumes results; the slave is the accumulator itself.
interface sm_sat_accum_if #(
    parameter int DW      = 36,
    parameter int ACC_LEN = 4
);
    localparam int CW = $clog2(ACC_LEN) + 1;

    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic [CW-1:0] acc_cnt;

    modport master (
        output clear, in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_sat, acc_cnt
    );

    modport slave (
        input  clear, in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_sat, acc_cnt
    );
endinterface

// File: rtl/sm_sat_accum.sv
// Saturating sign-magnitude accumulator: ACC_LEN beats in, one registered sum out the edge after the last beat.
// Input stalls only while a result is held un-consumed or clear is asserted; drain and reload can share a cycle.
module sm_sat_accum #(
    parameter int DW      = 36,
    parameter int ACC_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    sm_sat_accum_if.slave  io_bus
);
    localparam int CW = $clog2(ACC_LEN) + 1;
    localparam int MW = DW - 1;
    localparam logic [MW-1:0] MAG_MAX = '1;

    logic          r_acc_sign;
    logic [MW-1:0] r_acc_mag;
    logic [CW-1:0] r_cnt;
    logic          r_sticky;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_sat;

    logic          w_op_sign;
    logic [MW-1:0] w_op_mag;
    logic          w_a_ge_b;
    logic [DW-1:0] w_sum;
    logic          w_res_sign;
    logic [MW-1:0] w_res_mag;
    logic          w_sat;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;

    // A zero-magnitude operand is treated as +0 so it never flips the running sign.
    assign w_op_mag  = io_bus.in_data[MW-1:0];
    assign w_op_sign = (io_bus.in_data[DW-1] ^ io_bus.in_sub) & (|w_op_mag);
    assign w_a_ge_b  = (r_acc_mag >= w_op_mag);

    always_comb begin
        w_sum      = '0;
        w_res_sign = 1'b0;
        if (r_acc_sign == w_op_sign) begin
            w_sum      = {1'b0, r_acc_mag} + {1'b0, w_op_mag};
            w_res_sign = r_acc_sign;
        end else if (w_a_ge_b) begin
            w_sum      = {1'b0, r_acc_mag - w_op_mag};
            w_res_sign = r_acc_sign;
        end else begin
            w_sum      = {1'b0, w_op_mag - r_acc_mag};
            w_res_sign = w_op_sign;
        end
        w_sat     = w_sum[DW-1];
        w_res_mag = w_sat ? MAG_MAX : w_sum[MW-1:0];
        if (w_res_mag == '0) begin
            w_res_sign = 1'b0;
        end
    end

    assign w_in_ready = !io_bus.clear && !(r_out_valid && !io_bus.out_ready);
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == CW'(ACC_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_sign  <= 1'b0;
            r_acc_mag   <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A final beat loads after the drain above, so a same-cycle reload keeps out_valid high.
            if (io_bus.clear) begin
                r_acc_sign <= 1'b0;
                r_acc_mag  <= '0;
                r_cnt      <= '0;
                r_sticky   <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_out_data  <= {w_res_sign, w_res_mag};
                    r_out_sat   <= r_sticky | w_sat;
                    r_out_valid <= 1'b1;
                    r_acc_sign  <= 1'b0;
                    r_acc_mag   <= '0;
                    r_cnt       <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc_sign <= w_res_sign;
                    r_acc_mag  <= w_res_mag;
                    r_cnt      <= r_cnt + CW'(1);
                    r_sticky   <= r_sticky | w_sat;
                end
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sat   = r_out_sat;
    assign io_bus.acc_cnt   = r_cnt;
endmodule

// File: tb/tb_sm_sat_accum.sv
// Bench for sm_sat_accum at DW=8: directed frames, backpressure, clear/reset, an ACC_LEN=1 instance and a random run.
module tb_sm_sat_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sm_sat_accum_if #(.DW(8), .ACC_LEN(4)) bus ();
    sm_sat_accum_if #(.DW(8), .ACC_LEN(1)) bus1 ();

    sm_sat_accum #(.DW(8), .ACC_LEN(4)) dut  (.clk(clk), .rst(rst), .io_bus(bus));
    sm_sat_accum #(.DW(8), .ACC_LEN(1)) dut1 (.clk(clk), .rst(rst), .io_bus(bus1));

    function automatic int sm2int(input logic [7:0] x);
        return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    endfunction

    function automatic logic [7:0] int2sm(input int v);
        logic [7:0] r;
        r = (v < 0) ? {1'b1, 7'(-v)} : {1'b0, 7'(v)};
        return r;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic s);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sub   = s;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL beat_timeout in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
        checks++; if (bus.acc_cnt !== 3'd0) begin errors++; $display("FAIL reset_acc_cnt got=%0d exp=0", bus.acc_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send_beat(8'h0A, 1'b0);
        send_beat(8'h14, 1'b0);
        send_beat(8'h85, 1'b0);
        checks++; if (bus.acc_cnt !== 3'd3) begin errors++; $display("FAIL basic_cnt got=%0d exp=3", bus.acc_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
        send_beat(8'h03, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h1C) begin errors++; $display("FAIL basic_data got=%h exp=1c", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", bus.out_sat); end
        checks++; if (bus.acc_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt_wrap got=%0d exp=0", bus.acc_cnt); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        send_beat(8'h64, 1'b0);
        send_beat(8'h32, 1'b0);
        send_beat(8'h8A, 1'b0);
        send_beat(8'h8A, 1'b0);
        checks++; if (bus.out_data !== 8'h6B) begin errors++; $display("FAIL sat_data got=%h exp=6b", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", bus.out_sat); end
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        checks++; if (bus.out_data !== 8'h04) begin errors++; $display("FAIL sat_next_data got=%h exp=04", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_next_flag got=%b exp=0", bus.out_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_neg_zero();
        send_beat(8'h05, 1'b0);
        send_beat(8'h85, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'h00, 1'b0);
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL negzero_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL negzero_sat got=%b exp=0", bus.out_sat); end
        send_beat(8'h83, 1'b0);
        send_beat(8'h84, 1'b0);
        send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b0);
        checks++; if (bus.out_data !== 8'h87) begin errors++; $display("FAIL negsum_data got=%h exp=87", bus.out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        bus.in_sub   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, bus.out_valid); end
            checks++; if (bus.out_data !== 8'h04) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=04", k, bus.out_data); end
            checks++; if (bus.acc_cnt !== 3'd0) begin errors++; $display("FAIL bp_cnt cyc=%0d got=%0d exp=0", k, bus.acc_cnt); end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer got=%b exp=0", bus.out_valid); end
        checks++; if (bus.acc_cnt !== 3'd1) begin errors++; $display("FAIL bp_next_accept got=%0d exp=1", bus.acc_cnt); end
        for (int i = 0; i < 3; i++) send_beat(8'h02, 1'b0);
        checks++; if (bus.out_data !== 8'h08) begin errors++; $display("FAIL bp_next_data got=%h exp=08", bus.out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub();
        send_beat(8'h0A, 1'b1);
        send_beat(8'h0A, 1'b1);
        send_beat(8'h1E, 1'b0);
        send_beat(8'h00, 1'b0);
        checks++; if (bus.out_data !== 8'h0A) begin errors++; $display("FAIL sub_data got=%h exp=0a", bus.out_data); end
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 1'b1);
        checks++; if (bus.out_data !== 8'h7F) begin errors++; $display("FAIL sub_sat_data got=%h exp=7f", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sub_sat_flag got=%b exp=1", bus.out_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear_rst();
        send_beat(8'h32, 1'b0);
        send_beat(8'h32, 1'b0);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h32;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got=%b exp=0", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.acc_cnt !== 3'd0) begin errors++; $display("FAIL clear_cnt got=%0d exp=0", bus.acc_cnt); end
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        checks++; if (bus.out_data !== 8'h04) begin errors++; $display("FAIL clear_data got=%h exp=04", bus.out_data); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_beat(8'h01, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (bus.acc_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", bus.acc_cnt); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(8'h01, 1'b0);
        checks++; if (bus.acc_cnt !== 3'd1) begin errors++; $display("FAIL rst_restart_cnt got=%0d exp=1", bus.acc_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'h01, 1'b0);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clear_keeps_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h04) begin errors++; $display("FAIL clear_keeps_data got=%h exp=04", bus.out_data); end
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_pending_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_pending_data got=%h exp=00", bus.out_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[4];
        logic       s[4];
        logic [7:0] exp_d;
        d = '{8'h80, 8'h85, 8'hFF, 8'h7F};
        s = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.in_data = d[i];
            bus1.in_sub  = s[i];
            exp_d = int2sm(s[i] ? -sm2int(d[i]) : sm2int(d[i]));
            @(posedge clk);
            #1;
            checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, bus1.out_valid); end
            checks++; if (bus1.out_data !== exp_d) begin errors++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", i, bus1.out_data, exp_d); end
            checks++; if (bus1.out_sat !== 1'b0) begin errors++; $display("FAIL b2b_sat beat=%0d got=%b exp=0", i, bus1.out_sat); end
        end
        bus1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus1.out_valid); end
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        int  m_acc = 0;
        int  m_cnt = 0;
        bit  m_sticky = 1'b0;
        int  v;
        bit  sat;
        bit  exp_rdy;
        bus.out_ready = 1'b1;
        bus.clear     = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 800; c++) begin
            bus.clear     = ($urandom_range(0, 19) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sub    = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_data   = ($urandom_range(0, 1) != 0) ? 8'($urandom) : {1'($urandom_range(0, 1)), 7'($urandom_range(0, 40))};
            @(negedge clk);
            exp_rdy = !bus.clear && !(q.size() > 0 && !bus.out_ready);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy); end
            checks++; if (bus.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, q.size() > 0); end
            checks++; if (bus.acc_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_acc_cnt cyc=%0d got=%0d exp=%0d", c, bus.acc_cnt, m_cnt); end
            if (q.size() > 0) begin
                checks++; if ({bus.out_sat, bus.out_data} !== q[0]) begin errors++; $display("FAIL rnd_result cyc=%0d got sat=%b data=%h exp sat=%b data=%h", c, bus.out_sat, bus.out_data, q[0][8], q[0][7:0]); end
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.clear) begin
                m_acc = 0; m_cnt = 0; m_sticky = 1'b0;
            end else if (bus.in_valid && exp_rdy) begin
                v = m_acc + (bus.in_sub ? -sm2int(bus.in_data) : sm2int(bus.in_data));
                sat = 1'b0;
                if (v > 127)  begin v = 127;  sat = 1'b1; end
                if (v < -127) begin v = -127; sat = 1'b1; end
                if (m_cnt == 3) begin
                    q.push_back({m_sticky | sat, int2sm(v)});
                    m_acc = 0; m_cnt = 0; m_sticky = 1'b0;
                end else begin
                    m_acc = v; m_cnt++; m_sticky = m_sticky | sat;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.clear = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_sub = 1'b0;  bus.out_ready = 1'b1;
        bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_sub = 1'b0; bus1.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_neg_zero();
        test_backpressure();
        test_sub();
        test_clear_rst();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
